// File: rtl/axi_lite_arbiter_pkg.sv
// Shared AXI4-Lite definitions for the core's bus fabric.
//   RESP_OKAY   : AXI "OKAY" response code
//   arb_state_e : arbiter FSM states (2-bit, IDLE = 0)
package npc_axi_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD0  = 2'd1,
    ARB_RD1  = 2'd2,
    ARB_WR1  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bundle (AR, R, AW, W, B channels).
//   modport master : drives requests and response readies
//   modport slave  : drives request readies and responses
interface axi_lite_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/axi_lite_arbiter_rr2.sv
// Two-requester round-robin picker.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request per requester
//   en       : arbitration enabled this cycle
//   gnt[1:0] : one-hot grant (combinational), all-zero when nothing granted
// `last` remembers the most recent winner; it resets to 1 so requester 0
// wins the first tie.
module arb_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves gnt unassigned, which would infer a latch.
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master, one-slave AXI4-Lite arbiter, one transaction in flight.
//   clk, rst : clock, synchronous active-high reset
//   m0       : IFU port (read-only; its write channels are never granted)
//   m1       : LSU port (read and write)
//   s        : shared slave port
// In IDLE the round-robin picker chooses a master; the chosen master's
// channels are then wired straight through to the slave until the response
// handshake, after which the FSM returns to IDLE.
module axi_lite_arbiter
  import npc_axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic              clk,
  input logic              rst,
  axi_lite_arbiter_if.slave  m0,
  axi_lite_arbiter_if.slave  m1,
  axi_lite_arbiter_if.master s
);

  arb_state_e    state;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          m1_wr_req;
  logic [AW-1:0] rd_addr_sel;

  // Any write-side activity from m1 wins over its read.
  assign m1_wr_req = m1.awvalid | m1.wvalid;
  assign req       = {m1.arvalid | m1_wr_req, m0.arvalid};

  arb_rr2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (state == ARB_IDLE),
    .gnt (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt[0])      state <= ARB_RD0;
          else if (gnt[1]) state <= m1_wr_req ? ARB_WR1 : ARB_RD1;
        end
        ARB_RD0, ARB_RD1: if (s.rvalid && s.rready) state <= ARB_IDLE;
        ARB_WR1:          if (s.bvalid && s.bready) state <= ARB_IDLE;
        default:          state <= ARB_IDLE;
      endcase
    end
  end

  // Address/data/strobe follow m0 only while m0 owns the bus; otherwise m1.
  assign rd_addr_sel = (state == ARB_RD0) ? m0.araddr : m1.araddr;

  always_comb begin
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rdata   = {DW{1'b0}};
    m0.rresp   = RESP_OKAY;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m0.bresp   = RESP_OKAY;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rdata   = {DW{1'b0}};
    m1.rresp   = RESP_OKAY;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;
    m1.bresp   = RESP_OKAY;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awvalid  = 1'b0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    s.araddr   = rd_addr_sel;
    s.awaddr   = m1.awaddr;
    s.wdata    = m1.wdata;
    s.wstrb    = m1.wstrb;
    case (state)
      ARB_RD0: begin
        s.awaddr   = m0.awaddr;
        s.wdata    = m0.wdata;
        s.wstrb    = m0.wstrb;
        s.arvalid  = m0.arvalid;
        m0.arready = s.arready;
        m0.rvalid  = s.rvalid;
        m0.rdata   = s.rdata;
        m0.rresp   = s.rresp;
        s.rready   = m0.rready;
      end
      ARB_RD1: begin
        s.arvalid  = m1.arvalid;
        m1.arready = s.arready;
        m1.rvalid  = s.rvalid;
        m1.rdata   = s.rdata;
        m1.rresp   = s.rresp;
        s.rready   = m1.rready;
      end
      ARB_WR1: begin
        // AW and W pass independently; the slave joins them.
        s.awvalid  = m1.awvalid;
        m1.awready = s.awready;
        s.wvalid   = m1.wvalid;
        m1.wready  = s.wready;
        m1.bvalid  = s.bvalid;
        m1.bresp   = s.bresp;
        s.bready   = m1.bready;
      end
      default: ;
    endcase
  end

endmodule
